// File: rtl/ixu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : ixu_issue_arb
// Purpose  : Two-slot round-robin arbiter feeding a shared integer ALU through
//            a two-stage pipeline: issue register (I) and writeback
//            register (W).
//            The issue stage drives the ALU operands and forward selects.
//            The writeback stage holds the result until the consumer
//            accepts it.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            req_* (2 slots)               - request valid/ready and payload
//            alu_*                         - issue-stage fields to the ALU
//            alu_out                       - combinational ALU result
//            fwd_data                      - forwarded operand (= rsp_data)
//            rsp_*                         - writeback response with ready
//            flush                         - synchronous kill of all in-flight work
// Revision : 1.0  initial release
// ============================================================================
module ixu_issue_arb #(
  parameter int TAG_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_op,
  input  logic [23:0]          req_imm,
  input  logic [1:0]           req_is_imm,
  input  logic [9:0]           req_rs1,
  input  logic [9:0]           req_rs2,
  input  logic [9:0]           req_rd,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [3:0]           alu_op,
  output logic [11:0]          alu_imm,
  output logic                 alu_is_imm,
  output logic [4:0]           alu_rs1,
  output logic [4:0]           alu_rs2,
  output logic                 alu_is_nop,
  output logic                 alu_is_rs1_fwd,
  output logic                 alu_is_rs2_fwd,
  output logic [31:0]          fwd_data,
  input  logic [31:0]          alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_slot,
  output logic [4:0]           rsp_rd,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          rsp_data,
  input  logic                 flush
);

  // Issue-stage registers
  logic             i_valid_q, i_valid_d;
  logic             i_slot_q, i_slot_d;
  logic [3:0]       i_op_q, i_op_d;
  logic [11:0]      i_imm_q, i_imm_d;
  logic             i_is_imm_q, i_is_imm_d;
  logic [4:0]       i_rs1_q, i_rs1_d;
  logic [4:0]       i_rs2_q, i_rs2_d;
  logic [4:0]       i_rd_q, i_rd_d;
  logic [TAG_W-1:0] i_tag_q, i_tag_d;

  // Writeback-stage registers
  logic             w_valid_q, w_valid_d;
  logic             w_slot_q, w_slot_d;
  logic [4:0]       w_rd_q, w_rd_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;
  logic [31:0]      w_data_q, w_data_d;

  // Round-robin priority pointer
  logic             ptr_q, ptr_d;

  logic             w_free;
  logic             i_free;
  logic             gnt_slot;
  logic [1:0]       gnt;
  logic             xfer;

  assign w_free = !w_valid_q | rsp_ready;
  assign i_free = !i_valid_q | w_free;

  // Grant is suppressed during reset and flush so nothing is accepted that
  // would be discarded on the next edge.
  always_comb begin
    gnt      = 2'b00;
    gnt_slot = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_slot = ptr_q;
    end else begin
      gnt_slot = req_valid[1];
    end
    if (rst_n && i_free && !flush && (req_valid != 2'b00)) begin
      gnt[gnt_slot] = 1'b1;
    end
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    ptr_d      = ptr_q;
    i_valid_d  = i_valid_q;
    i_slot_d   = i_slot_q;
    i_op_d     = i_op_q;
    i_imm_d    = i_imm_q;
    i_is_imm_d = i_is_imm_q;
    i_rs1_d    = i_rs1_q;
    i_rs2_d    = i_rs2_q;
    i_rd_d     = i_rd_q;
    i_tag_d    = i_tag_q;
    w_valid_d  = w_valid_q;
    w_slot_d   = w_slot_q;
    w_rd_d     = w_rd_q;
    w_tag_d    = w_tag_q;
    w_data_d   = w_data_q;

    if (xfer) begin
      ptr_d      = ~gnt_slot;
      i_slot_d   = gnt_slot;
      i_op_d     = gnt_slot ? req_op[7:4]           : req_op[3:0];
      i_imm_d    = gnt_slot ? req_imm[23:12]        : req_imm[11:0];
      i_is_imm_d = gnt_slot ? req_is_imm[1]         : req_is_imm[0];
      i_rs1_d    = gnt_slot ? req_rs1[9:5]          : req_rs1[4:0];
      i_rs2_d    = gnt_slot ? req_rs2[9:5]          : req_rs2[4:0];
      i_rd_d     = gnt_slot ? req_rd[9:5]           : req_rd[4:0];
      i_tag_d    = gnt_slot ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    end

    if (i_free) begin
      i_valid_d = xfer;
    end

    // W captures whatever I holds; an empty I clears W.
    if (w_free) begin
      w_valid_d = i_valid_q;
      if (i_valid_q) begin
        w_slot_d = i_slot_q;
        w_rd_d   = i_rd_q;
        w_tag_d  = i_tag_q;
        w_data_d = alu_out;
      end
    end

    // A response handshaking in the flush cycle still counts as accepted;
    // only the valids drop, the pointer keeps its value.
    if (flush) begin
      i_valid_d = 1'b0;
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      i_valid_q  <= 1'b0;
      i_slot_q   <= 1'b0;
      i_op_q     <= '0;
      i_imm_q    <= '0;
      i_is_imm_q <= 1'b0;
      i_rs1_q    <= '0;
      i_rs2_q    <= '0;
      i_rd_q     <= '0;
      i_tag_q    <= '0;
      w_valid_q  <= 1'b0;
      w_slot_q   <= 1'b0;
      w_rd_q     <= '0;
      w_tag_q    <= '0;
      w_data_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      i_valid_q  <= i_valid_d;
      i_slot_q   <= i_slot_d;
      i_op_q     <= i_op_d;
      i_imm_q    <= i_imm_d;
      i_is_imm_q <= i_is_imm_d;
      i_rs1_q    <= i_rs1_d;
      i_rs2_q    <= i_rs2_d;
      i_rd_q     <= i_rd_d;
      i_tag_q    <= i_tag_d;
      w_valid_q  <= w_valid_d;
      w_slot_q   <= w_slot_d;
      w_rd_q     <= w_rd_d;
      w_tag_q    <= w_tag_d;
      w_data_q   <= w_data_d;
    end
  end

  // Issue-stage fields read as zero when I is empty.
  assign alu_is_nop = !i_valid_q;
  assign alu_op     = i_valid_q ? i_op_q     : 4'd0;
  assign alu_imm    = i_valid_q ? i_imm_q    : 12'd0;
  assign alu_is_imm = i_valid_q ? i_is_imm_q : 1'b0;
  assign alu_rs1    = i_valid_q ? i_rs1_q    : 5'd0;
  assign alu_rs2    = i_valid_q ? i_rs2_q    : 5'd0;

  // Register 0 is hard-wired zero and must never be forwarded.
  assign alu_is_rs1_fwd = i_valid_q & w_valid_q & (i_rs1_q == w_rd_q) & (w_rd_q != 5'd0);
  assign alu_is_rs2_fwd = i_valid_q & w_valid_q & (i_rs2_q == w_rd_q) & (w_rd_q != 5'd0);

  assign rsp_valid = w_valid_q;
  assign rsp_slot  = w_slot_q;
  assign rsp_rd    = w_rd_q;
  assign rsp_tag   = w_tag_q;
  assign rsp_data  = w_data_q;
  assign fwd_data  = w_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ixu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ixu_issue_arb
// Purpose  : Directed self-checking bench for ixu_issue_arb. A stand-in ALU
//            returns {16'h0, op, imm} so every result is hand-predictable.
// Revision : 1.0  initial release
// ============================================================================
module tb_ixu_issue_arb;
  localparam int TAG_W = 3;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [7:0]         req_op;
  logic [23:0]        req_imm;
  logic [1:0]         req_is_imm;
  logic [9:0]         req_rs1;
  logic [9:0]         req_rs2;
  logic [9:0]         req_rd;
  logic [2*TAG_W-1:0] req_tag;
  logic [3:0]         alu_op;
  logic [11:0]        alu_imm;
  logic               alu_is_imm;
  logic [4:0]         alu_rs1;
  logic [4:0]         alu_rs2;
  logic               alu_is_nop;
  logic               alu_is_rs1_fwd;
  logic               alu_is_rs2_fwd;
  logic [31:0]        fwd_data;
  logic [31:0]        alu_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_slot;
  logic [4:0]         rsp_rd;
  logic [TAG_W-1:0]   rsp_tag;
  logic [31:0]        rsp_data;
  logic               flush;

  int errors = 0;
  int checks = 0;

  ixu_issue_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_imm(req_imm), .req_is_imm(req_is_imm), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_rd(req_rd), .req_tag(req_tag),
    .alu_op(alu_op), .alu_imm(alu_imm), .alu_is_imm(alu_is_imm),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_is_nop(alu_is_nop),
    .alu_is_rs1_fwd(alu_is_rs1_fwd), .alu_is_rs2_fwd(alu_is_rs2_fwd),
    .fwd_data(fwd_data), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slot(rsp_slot),
    .rsp_rd(rsp_rd), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .flush(flush)
  );

  assign alu_out = {16'h0, alu_op, alu_imm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [3:0] op, input logic [11:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [TAG_W-1:0] tag);
    if (s == 0) begin
      req_op[3:0] = op;  req_imm[11:0] = imm; req_rs1[4:0] = rs1;
      req_rs2[4:0] = rs2; req_rd[4:0] = rd;   req_tag[TAG_W-1:0] = tag;
    end else begin
      req_op[7:4] = op;  req_imm[23:12] = imm; req_rs1[9:5] = rs1;
      req_rs2[9:5] = rs2; req_rd[9:5] = rd;    req_tag[2*TAG_W-1:TAG_W] = tag;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1; req_is_imm = 2'b00;
    req_op = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_tag = '0;
    set_slot(0, 4'h1, 12'h010, 5'd0, 5'd0, 5'd1, 3'd5);
    set_slot(1, 4'h2, 12'h020, 5'd0, 5'd0, 5'd2, 3'd6);
    req_valid = 2'b11;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_nop",       32'(alu_is_nop), 32'h1);
    chk("rst_fwd",       32'({alu_is_rs1_fwd, alu_is_rs2_fwd}), 32'h0);

    // Both slots valid every cycle: grants alternate, responses trail by 2
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 1) chk("rr_alu_op", 32'(alu_op), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_slot",  32'(rsp_slot), 32'((k - 2) % 2));
        chk("rr_rsp_data",  rsp_data, ((k - 2) % 2 == 0) ? 32'h1010 : 32'h2020);
        chk("rr_rsp_tag",   32'(rsp_tag), ((k - 2) % 2 == 0) ? 32'h5 : 32'h6);
      end
    end
    @(negedge clk); req_valid = 2'b00; #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("drain_nop",       32'(alu_is_nop), 32'h1);

    // Forwarding from W into I (pointer is 0 here)
    set_slot(1, 4'h0, 12'h007, 5'd0, 5'd0, 5'd5, 3'd1);
    @(negedge clk); req_valid = 2'b10; #1;
    chk("fwd_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    set_slot(0, 4'h0, 12'h003, 5'd5, 5'd6, 5'd7, 3'd2);
    req_valid = 2'b01; #1;
    chk("fwd_grant0", 32'(req_ready), 32'h1);
    chk("fwd_i_rs1",  32'(alu_rs1), 32'h0);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("fwd_rsp_data", rsp_data, 32'h7);
    chk("fwd_rsp_rd",   32'(rsp_rd), 32'h5);
    chk("fwd_rsp_slot", 32'(rsp_slot), 32'h1);
    chk("fwd_alu_rs1",  32'(alu_rs1), 32'h5);
    chk("fwd_rs1_flag", 32'(alu_is_rs1_fwd), 32'h1);
    chk("fwd_rs2_flag", 32'(alu_is_rs2_fwd), 32'h0);
    chk("fwd_data",     fwd_data, 32'h7);

    // Same pattern with rd = 0: never forwarded
    set_slot(1, 4'h0, 12'h007, 5'd0, 5'd0, 5'd0, 3'd3);
    @(negedge clk); req_valid = 2'b10; #1;
    chk("r0_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    set_slot(0, 4'h0, 12'h003, 5'd0, 5'd0, 5'd7, 3'd4);
    req_valid = 2'b01;
    @(negedge clk); req_valid = 2'b00; #1;
    chk("r0_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r0_rsp_rd",    32'(rsp_rd), 32'h0);
    chk("r0_nop",       32'(alu_is_nop), 32'h0);
    chk("r0_fwd",       32'({alu_is_rs1_fwd, alu_is_rs2_fwd}), 32'h0);

    // Backpressure with I and W full (pointer is 1 here)
    @(negedge clk);
    @(negedge clk);
    set_slot(0, 4'h3, 12'h0AA, 5'd0, 5'd0, 5'd3, 3'd2);
    set_slot(1, 4'h4, 12'h0BB, 5'd0, 5'd0, 5'd4, 3'd3);
    req_valid = 2'b11; #1;
    chk("bp_grant_ptr1", 32'(req_ready), 32'h2);
    @(negedge clk); #1;
    chk("bp_grant_next", 32'(req_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); rsp_ready = 1'b0; #1;
      chk("bp_ready",     32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_slot",  32'(rsp_slot), 32'h1);
      chk("bp_rsp_data",  rsp_data, 32'h40BB);
      chk("bp_rsp_tag",   32'(rsp_tag), 32'h3);
      chk("bp_i_hold",    32'(alu_op), 32'h3);
    end
    @(negedge clk); rsp_ready = 1'b1; req_valid = 2'b00; #1;
    chk("bp_rel_data", rsp_data, 32'h40BB);
    @(negedge clk); #1;
    chk("bp_2nd_valid", 32'(rsp_valid), 32'h1);
    chk("bp_2nd_slot",  32'(rsp_slot), 32'h0);
    chk("bp_2nd_data",  rsp_data, 32'h30AA);
    chk("bp_2nd_tag",   32'(rsp_tag), 32'h2);
    @(negedge clk); #1;
    chk("bp_empty", 32'(rsp_valid), 32'h0);

    // Flush with I and W valid (pointer is 1 here)
    @(negedge clk); req_valid = 2'b11; #1;
    chk("fl_grant1", 32'(req_ready), 32'h2);
    @(negedge clk); #1;
    chk("fl_grant0", 32'(req_ready), 32'h1);
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_ready",     32'(req_ready), 32'h0);
    chk("fl_pre_valid", 32'(rsp_valid), 32'h1);
    chk("fl_pre_nop",   32'(alu_is_nop), 32'h0);
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("fl_nop",       32'(alu_is_nop), 32'h1);
    chk("fl_ptr_kept",  32'(req_ready), 32'h2);

    // Asynchronous reset between edges, pointer left at 1 before it
    @(negedge clk); #1;
    chk("ar_grant0", 32'(req_ready), 32'h1);
    @(negedge clk); #1;
    chk("ar_pre_valid", 32'(rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("ar_nop",       32'(alu_is_nop), 32'h1);
    chk("ar_ready",     32'(req_ready), 32'h0);
    chk("ar_fwd",       32'({alu_is_rs1_fwd, alu_is_rs2_fwd}), 32'h0);
    chk("ar_rsp_data",  rsp_data, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("ar_no_ghost", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("ar_new_valid", 32'(rsp_valid), 32'h1);
    chk("ar_new_slot",  32'(rsp_slot), 32'h0);
    chk("ar_new_data",  rsp_data, 32'h30AA);
    @(negedge clk); #1;
    chk("ar_end_empty", 32'(rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
